plot_capture: RTL and testbench

PLOT_CAPTURE -- requirements
Module: plot_capture

---
 rtl/plot_capture_pkg.sv | 14 +
 rtl/plot_capture_fb_ram.sv | 28 ++
 rtl/plot_capture.sv | 156 +++++++++++++++
 tb/tb_plot_capture.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/plot_capture_pkg.sv
// Shared framebuffer geometry, field widths and read-out FSM state encoding
// for plot_capture.
package plot_capture_pkg;
   localparam int FB_WIDTH  = 160;
   localparam int FB_HEIGHT = 120;
   localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
   localparam int X_W       = 8;
   localparam int Y_W       = 7;
   localparam int COL_W     = 3;
   localparam int ADDR_W    = 15;
   localparam int CNT_W     = 15;

   typedef enum logic [2:0] {IDLE, CLR, RD, OUT, DONE} state_t;
endpackage

// File: rtl/plot_capture_fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// A same-address write and read in one cycle returns the old data.
module fb_ram
   import plot_capture_pkg::*;
#(
   parameter int DEPTH = FB_DEPTH,
   parameter int AW    = ADDR_W,
   parameter int DW    = COL_W
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);
   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;

   // Read data only updates on i_re so it holds while the consumer stalls.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/plot_capture.sv
// Plot capture framebuffer with clear and valid/ready raster read-out.
// Define PLOT_CAPTURE_STATS_EN to build the saturating plot/drop counters.
module plot_capture
   import plot_capture_pkg::*;
#(
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [X_W-1:0]   vga_x,
   input  logic [Y_W-1:0]   vga_y,
   input  logic [COL_W-1:0] vga_colour,
   input  logic             vga_plot,
   input  logic             start,
   input  logic             clear,
   output logic [X_W-1:0]   out_x,
   output logic [Y_W-1:0]   out_y,
   output logic [COL_W-1:0] out_colour,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] plot_count,
   output logic [CNT_W-1:0] drop_count
);
   localparam int                DEPTH  = WIDTH * HEIGHT;
   localparam logic [X_W-1:0]    LAST_X = X_W'(WIDTH - 1);
   localparam logic [Y_W-1:0]    LAST_Y = Y_W'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);

   state_t              r_state;
   logic [X_W-1:0]      r_x;
   logic [Y_W-1:0]      r_y;
   logic [ADDR_W-1:0]   r_clr_addr;
   logic                r_busy, r_done, r_valid, r_last;

   logic                w_accept, w_clr_we, w_we, w_re;
   logic [ADDR_W-1:0]   w_plot_addr, w_rd_addr, w_waddr;
   logic [COL_W-1:0]    w_wdata;

   assign w_accept    = vga_plot && (vga_x <= LAST_X) && (vga_y <= LAST_Y) && (r_state != CLR);
   assign w_plot_addr = ADDR_W'(vga_y) * ADDR_W'(WIDTH) + ADDR_W'(vga_x);
   assign w_rd_addr   = ADDR_W'(r_y) * ADDR_W'(WIDTH) + ADDR_W'(r_x);
   // The clear sweep owns the write port; external plots are dropped meanwhile.
   assign w_clr_we    = (r_state == CLR) && !rst;
   assign w_we        = w_clr_we || w_accept;
   assign w_waddr     = w_clr_we ? r_clr_addr : w_plot_addr;
   assign w_wdata     = w_clr_we ? '0 : vga_colour;
   assign w_re        = (r_state == RD);

   fb_ram #(.DEPTH(DEPTH), .AW(ADDR_W), .DW(COL_W)) u_fb (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (w_re),
      .i_raddr (w_rd_addr),
      .o_rdata (out_colour)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_x        <= '0;
         r_y        <= '0;
         r_clr_addr <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (clear) begin
                  r_state    <= CLR;
                  r_clr_addr <= '0;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
               end else if (start) begin
                  r_state <= RD;
                  r_x     <= '0;
                  r_y     <= '0;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            CLR: begin
               if (r_clr_addr == LAST_A) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_clr_addr <= r_clr_addr + ADDR_W'(1);
               end
            end
            RD: begin
               r_state <= OUT;
               r_valid <= 1'b1;
               r_last  <= (r_x == LAST_X) && (r_y == LAST_Y);
            end
            OUT: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  if (r_last) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= RD;
                     if (r_x == LAST_X) begin
                        r_x <= '0;
                        r_y <= r_y + Y_W'(1);
                     end else begin
                        r_x <= r_x + X_W'(1);
                     end
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_x     = r_x;
   assign out_y     = r_y;
   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign busy      = r_busy;
   assign done      = r_done;

`ifdef PLOT_CAPTURE_STATS_EN
   logic             w_drop;
   logic [CNT_W-1:0] r_plot_cnt, r_drop_cnt;

   assign w_drop = vga_plot && !w_accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_plot_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_accept && !(&r_plot_cnt)) r_plot_cnt <= r_plot_cnt + CNT_W'(1);
         if (w_drop && !(&r_drop_cnt)) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
   end

   assign plot_count = r_plot_cnt;
   assign drop_count = r_drop_cnt;
`else
   assign plot_count = '0;
   assign drop_count = '0;
`endif
endmodule

// File: tb/tb_plot_capture.sv
// Directed bench for plot_capture: clear, plots, full and stalled scans,
// same-cycle read/write collision and reset abort.
module tb_plot_capture;
`ifdef PLOT_CAPTURE_STATS_EN
   localparam int ST = 1;
`else
   localparam int ST = 0;
`endif

   logic        clk, rst;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot, start, clear, out_ready;
   logic [7:0]  out_x;
   logic [6:0]  out_y;
   logic [2:0]  out_colour;
   logic        out_valid, out_last, busy, done;
   logic [14:0] plot_count, drop_count;

   int total = 0, bad = 0;
   int errs, hs, stalls, lasts, cyc, c500, c1125;
   bit coll, p2;
   logic [2:0] em [19200];

   plot_capture dut (
      .clk(clk), .rst(rst), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .start(start), .clear(clear), .out_x(out_x), .out_y(out_y),
      .out_colour(out_colour), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done), .plot_count(plot_count),
      .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic plot(input int x, input int y, input int c);
      vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
      step();
      vga_plot = 1'b0;
   endtask

   // Scan with a bench-side expected framebuffer; rst_at<0 runs the full frame.
   task automatic scan(input bit rnd, input int rst_at);
      bit sp;
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] pc, expc;
      logic pl;
      int ex, ey;
      errs = 0; hs = 0; stalls = 0; lasts = 0; cyc = 0; sp = 0; ex = 0; ey = 0;
      expc = 0; px = 0; py = 0; pc = 0; pl = 0;
      start = 1'b1; step(); start = 1'b0;
      while (!done && cyc < 80000 && hs != rst_at) begin
         vga_plot = 1'b0;
         if (!busy) errs++;
         if (out_valid) begin
            if (sp && {out_x, out_y, out_colour, out_last} !== {px, py, pc, pl}) errs++;
            if (out_x !== 8'(ex) || out_y !== 7'(ey) || out_colour !== expc) errs++;
            if (out_last !== (ex == 159 && ey == 119)) errs++;
            if (ex + ey*160 == 500) c500 = int'(out_colour);
            if (ex + ey*160 == 1125) c1125 = int'(out_colour);
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd && hs == 700 && !p2) begin
               vga_x = 8'd150; vga_y = 7'd119; vga_colour = 3'd2; vga_plot = 1'b1;
               em[19190] = 3'd2; p2 = 1;
            end
            if (out_ready) begin
               hs++; sp = 0;
               if (out_last) lasts++;
               if (ex == 159) begin ex = 0; ey++; end else ex++;
            end else begin
               stalls++; sp = 1;
               px = out_x; py = out_y; pc = out_colour; pl = out_last;
            end
         end else begin
            if (sp) errs++;
            expc = em[ex + ey*160];
            // Write the very address being read this cycle: old data must come back.
            if (rnd && hs == 500 && !coll) begin
               vga_x = 8'(ex); vga_y = 7'(ey); vga_colour = 3'd6; vga_plot = 1'b1;
               em[ex + ey*160] = 3'd6; coll = 1;
            end
         end
         step(); cyc++;
      end
      vga_plot = 1'b0;
   endtask

   initial begin
      rst = 1'b1; vga_x = 0; vga_y = 0; vga_colour = 0; vga_plot = 0;
      start = 0; clear = 0; out_ready = 1; coll = 0; p2 = 0; c500 = -1; c1125 = -1;
      step(); step();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_x", out_x, 0);
      chk("rst_y", out_y, 0);
      chk("rst_pcnt", plot_count, 0);
      chk("rst_dcnt", drop_count, 0);
      rst = 1'b0; step();

      // clear and start together: clear wins; start during CLR is ignored
      clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
      chk("clr_busy", busy, 1);
      chk("clr_done0", done, 0);
      cyc = 0;
      while (!done && cyc < 25000) begin
         start = (cyc == 100);
         if (cyc == 150) begin
            chk("clr_mid_busy", busy, 1);
            chk("clr_mid_valid", out_valid, 0);
         end
         if (cyc == 200) begin
            vga_x = 8'd1; vga_y = 7'd1; vga_colour = 3'd7; vga_plot = 1'b1;
         end else vga_plot = 1'b0;
         step(); cyc++;
      end
      start = 1'b0; vga_plot = 1'b0;
      chk("clr_cycles", cyc, 19200);
      chk("clr_done", done, 1);
      chk("clr_busy_end", busy, 0);
      for (int i = 0; i < 19200; i++) em[i] = 3'd0;
      step(); step(); step();
      chk("done_hold", done, 1);

      plot(5, 7, 5); em[1125] = 3'd5;
      plot(160, 0, 7);
      plot(0, 120, 7);
      step();
      chk("pcnt_1", plot_count, 32'(ST * 1));
      chk("dcnt_3", drop_count, 32'(ST * 3));
      chk("done_plots", done, 1);

      // full frame with random back-pressure, collision and mid-scan plot
      scan(1'b1, -1);
      chk("b_errs", errs, 0);
      chk("b_hs", hs, 19200);
      chk("b_last", lasts, 1);
      chk("b_cyc", cyc, 38400 + stalls);
      chk("b_done", done, 1);
      chk("b_busy", busy, 0);
      chk("b_c1125", c1125, 5);
      chk("b_coll_old", c500, 0);
      chk("b_pcnt", plot_count, 32'(ST * 3));
      chk("b_dcnt", drop_count, 32'(ST * 3));

      // reset at pixel 1000 aborts the scan immediately
      out_ready = 1'b1;
      scan(1'b0, 1000);
      chk("c_errs", errs, 0);
      chk("c_hs", hs, 1000);
      rst = 1'b1; step();
      chk("c_valid", out_valid, 0);
      chk("c_busy", busy, 0);
      chk("c_done", done, 0);
      chk("c_last", out_last, 0);
      chk("c_x", out_x, 0);
      chk("c_pcnt", plot_count, 0);
      rst = 1'b0; step();

      // restarted scan sees data written before the reset
      c500 = -1; c1125 = -1;
      scan(1'b0, 1200);
      chk("d_errs", errs, 0);
      chk("d_hs", hs, 1200);
      chk("d_c500", c500, 6);
      chk("d_c1125", c1125, 5);
      rst = 1'b1; step(); rst = 1'b0; step();
      chk("d_rst_valid", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
